// File: rtl/pic_ack_sequencer.sv
// Interrupt acknowledge and priority controller for an 8259-style PIC.
// Decides when to raise INT, runs the two-pulse INTA handshake (set ISR,
// then drive the vector) and owns the in-service register, including EOI
// clearing and priority rotation.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous reset, active-low
//   irr          interrupt request register (edge-latched upstream)
//   imr          interrupt mask register, 1 = masked
//   inta_n       CPU acknowledge, active-low, already synchronised
//   vector_base  ICW2 T7-T3
//   auto_eoi     clear the ISR bit at the end of the second INTA pulse
//   eoi_valid    one-cycle EOI command strobe
//   eoi_specific 1 = specific EOI using eoi_level, 0 = non-specific
//   eoi_rotate   rotate priority on this EOI
//   eoi_level    level for a specific EOI
//   prio_valid   one-cycle set-priority strobe
//   prio_level   new lowest-priority level
//   int_out      registered interrupt request to the CPU
//   isr          in-service register
//   clear_irr    one-cycle one-hot pulse clearing the acknowledged IRR bit
//   vector_out   {vector_base, level}, holds when not valid
//   vector_valid vector_out is being driven onto the data bus
module pic_ack_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic       eoi_rotate,
  input  logic [2:0] eoi_level,
  input  logic       prio_valid,
  input  logic [2:0] prio_level,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [7:0] clear_irr,
  output logic [7:0] vector_out,
  output logic       vector_valid
);

  typedef enum logic [1:0] {StIdle, StAck1, StWait2, StAck2} state_e;

  state_e     state_q, state_d;
  logic [2:0] lowest_q, lowest_d;
  logic       inta_prev_q;
  logic [2:0] ack_level_q, ack_level_d;
  logic       spurious_q, spurious_d;
  logic       int_out_q, int_out_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] clear_irr_q, clear_irr_d;
  logic [7:0] vector_out_q, vector_out_d;
  logic       vector_valid_q, vector_valid_d;

  // Returns {found, level} for the highest-priority set bit. Scans from the
  // lowest priority upward so the last hit (highest priority) wins.
  function automatic logic [3:0] find_highest(input logic [7:0] bits, input logic [2:0] lowest);
    logic [3:0] res;
    logic [2:0] lvl;
    res = 4'd0;
    for (int i = 8; i >= 1; i--) begin
      lvl = lowest + 3'(i);
      if (bits[lvl]) res = {1'b1, lvl};
    end
    return res;
  endfunction

  logic [3:0] cand, hisr;
  logic       cand_vld, hisr_vld;
  logic [2:0] cand_lvl, hisr_lvl;
  logic [2:0] cand_rank, hisr_rank;
  logic       req;
  logic       inta_fall;

  always_comb begin
    cand      = find_highest(irr & ~imr, lowest_q);
    hisr      = find_highest(isr_q, lowest_q);
    cand_vld  = cand[3];
    cand_lvl  = cand[2:0];
    hisr_vld  = hisr[3];
    hisr_lvl  = hisr[2:0];
    // Rank 0 is the highest priority (lowest_q + 1).
    cand_rank = cand_lvl - lowest_q - 3'd1;
    hisr_rank = hisr_lvl - lowest_q - 3'd1;
    req       = cand_vld && (!hisr_vld || (cand_rank < hisr_rank));
    inta_fall = inta_prev_q && !inta_n;
  end

  logic [7:0] set_mask, ack_clr_mask, eoi_clr_mask;
  logic       eoi_hit;
  logic [2:0] eoi_lvl;

  // Acknowledge sequencer
  always_comb begin
    state_d        = state_q;
    int_out_d      = int_out_q;
    ack_level_d    = ack_level_q;
    spurious_d     = spurious_q;
    clear_irr_d    = 8'd0;
    vector_out_d   = vector_out_q;
    vector_valid_d = vector_valid_q;
    set_mask       = 8'd0;
    ack_clr_mask   = 8'd0;
    unique case (state_q)
      StIdle: begin
        int_out_d = req;
        if (inta_fall && int_out_q) begin
          state_d   = StAck1;
          int_out_d = 1'b0;
          if (cand_vld) begin
            ack_level_d = cand_lvl;
            spurious_d  = 1'b0;
            set_mask    = 8'd1 << cand_lvl;
            clear_irr_d = 8'd1 << cand_lvl;
          end else begin
            // Request withdrawn before the acknowledge: answer with level 7.
            ack_level_d = 3'd7;
            spurious_d  = 1'b1;
          end
        end
      end
      StAck1: begin
        int_out_d = 1'b0;
        state_d   = StWait2;
      end
      StWait2: begin
        int_out_d = 1'b0;
        // A falling edge implies the first pulse has already ended.
        if (inta_fall) begin
          state_d        = StAck2;
          vector_out_d   = {vector_base, ack_level_q};
          vector_valid_d = 1'b1;
        end
      end
      StAck2: begin
        int_out_d = 1'b0;
        if (inta_n) begin
          vector_valid_d = 1'b0;
          state_d        = StIdle;
          if (auto_eoi && !spurious_q) ack_clr_mask = 8'd1 << ack_level_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // EOI, priority and ISR update
  always_comb begin
    eoi_hit      = 1'b0;
    eoi_lvl      = 3'd0;
    eoi_clr_mask = 8'd0;
    if (eoi_valid) begin
      if (eoi_specific) begin
        eoi_lvl = eoi_level;
        eoi_hit = isr_q[eoi_level];
      end else begin
        eoi_lvl = hisr_lvl;
        eoi_hit = hisr_vld;
      end
      if (eoi_hit) eoi_clr_mask = 8'd1 << eoi_lvl;
    end
    // Set wins over a clear of the same bit.
    isr_d = (isr_q & ~(eoi_clr_mask | ack_clr_mask)) | set_mask;
    lowest_d = lowest_q;
    if (prio_valid) lowest_d = prio_level;
    if (eoi_valid && eoi_rotate && eoi_hit) lowest_d = eoi_lvl;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      lowest_q       <= 3'd7;
      inta_prev_q    <= 1'b1;
      ack_level_q    <= 3'd0;
      spurious_q     <= 1'b0;
      int_out_q      <= 1'b0;
      isr_q          <= 8'd0;
      clear_irr_q    <= 8'd0;
      vector_out_q   <= 8'd0;
      vector_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lowest_q       <= lowest_d;
      inta_prev_q    <= inta_n;
      ack_level_q    <= ack_level_d;
      spurious_q     <= spurious_d;
      int_out_q      <= int_out_d;
      isr_q          <= isr_d;
      clear_irr_q    <= clear_irr_d;
      vector_out_q   <= vector_out_d;
      vector_valid_q <= vector_valid_d;
    end
  end

  assign int_out      = int_out_q;
  assign isr          = isr_q;
  assign clear_irr    = clear_irr_q;
  assign vector_out   = vector_out_q;
  assign vector_valid = vector_valid_q;

endmodule

// File: doc/pic_ack_sequencer.md
# pic_ack_sequencer

Interrupt acknowledge and priority controller for the 8259-style PIC. It sits between the request/mask registers and the CPU INTA handshake. It decides when to raise INT and sequences the two-pulse INTA cycle (set ISR, then drive the vector). It owns the in-service register, including EOI clearing and priority rotation.

## Interface
Parameters:
- None. The block has fixed 8 request lines (IR0–IR7) and fixed 2-pulse INTA (8086 mode).

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low
- irr  input  8  interrupt request register (level, already edge-latched upstream)
- imr  input  8  interrupt mask register; 1 = masked
- inta_n  input  1  CPU acknowledge, active-low, synchronous to clock (synchronised upstream)
- vector_base  input  5  ICW2 T7–T3
- auto_eoi  input  1  1 = clear ISR bit at end of second INTA
- eoi_valid  input  1  one-cycle EOI command strobe
- eoi_specific  input  1  1 = specific EOI (use eoi_level), 0 = non-specific
- eoi_rotate  input  1  1 = rotate priority on this EOI
- eoi_level  input  3  level for specific EOI
- prio_valid  input  1  one-cycle set-priority strobe
- prio_level  input  3  new lowest-priority level
- int_out  output  1  interrupt to CPU, registered
- isr  output  8  in-service register
- clear_irr  output  8  one-cycle one-hot pulse clearing the acknowledged IRR bit
- vector_out  output  8  {vector_base, level}
- vector_valid  output  1  vector_out valid (drive data bus)

## Operation
- Priority order:
  - lowest_reg (3 bits, reset 7) holds the lowest-priority level.
  - Priority runs highest to lowest as lowest_reg+1, lowest_reg+2, … mod 8.
  - With reset value 7, IR0 is highest and IR7 is lowest.
- Candidate: the highest-priority set bit of irr & ~imr.
- Highest-in-service: the highest-priority set bit of isr.
- Request condition: a candidate exists AND (isr == 0 OR the candidate's priority is strictly above highest-in-service). Equal or lower priority is blocked (fully nested).
- FSM states: IDLE, ACK1, WAIT2, ACK2.
  - IDLE:
    - int_out <= request condition.
    - A falling edge on inta_n (previous sample 1, current 0) while int_out=1 → ACK1.
    - inta_n edges while int_out=0 are ignored.
  - ACK1 (entered on edge cycle E):
    - ack_level is latched from the candidate at cycle E.
    - If no candidate exists at E (request withdrawn), ack_level=7 and spurious=1; ISR and IRR are untouched.
    - Otherwise isr[ack_level] is set and clear_irr[ack_level] pulses for one cycle.
    - int_out <= 0.
    - Transition → WAIT2.
  - WAIT2: wait for inta_n rising, then falling → ACK2.
  - ACK2:
    - vector_out = {vector_base, ack_level}; vector_valid=1 while inta_n=0.
    - On inta_n rising: vector_valid=0; if auto_eoi=1 and spurious=0, clear isr[ack_level]; → IDLE.
- EOI (eoi_valid=1, any state):
  - Non-specific EOI clears the highest-in-service bit; if isr==0, no change.
  - Specific EOI clears isr[eoi_level].
  - If eoi_rotate=1 and a bit was cleared, lowest_reg <= cleared level.
- Set-priority: prio_valid=1 → lowest_reg <= prio_level. A simultaneous eoi_rotate takes precedence.
- ISR update: isr_next = (isr & ~clr_mask) | set_mask. A set and a clear of the same bit in one cycle leaves the bit set.
- vector_out holds its last value when vector_valid=0.

## Timing
- Reset values:
  - int_out=0, isr=0, clear_irr=0, vector_out=0, vector_valid=0.
  - lowest_reg=7, FSM=IDLE, spurious=0, inta_n previous-sample register=1.
- Request to int_out: 1 cycle (registered).
- INTA pulse 1:
  - Falling edge sampled at cycle E.
  - isr bit and clear_irr pulse visible at E+1.
  - int_out low at E+1.
- INTA pulse 2:
  - vector_valid high from cycle F+1 (F = falling-edge sample) until the cycle after inta_n is sampled high.
  - Auto-EOI clear is visible the cycle after the rising sample.
- EOI and set-priority: effects visible the cycle after the strobe. The request condition uses registered isr, so int_out may re-assert 2 cycles after the EOI strobe.
- Reset mid-operation:
  - Reset is asynchronous and returns everything to reset values immediately.
  - Any in-flight acknowledge is abandoned with no vector driven.
- Minimum INTA pulse width and gap: 1 cycle each.

## Test plan
- Single request:
  - Stimulus: irr=0x08, imr=0, vector_base=0x11.
  - Required: int_out rises 1 cycle later.
  - After INTA1: isr=0x08, clear_irr=0x08 for one cycle.
  - On INTA2: vector_out=0x8B, vector_valid=1.
  - Non-specific EOI then gives isr=0x00.
- Nesting:
  - Stimulus: irr=0x20 is acknowledged (isr=0x20); then irr=0x24.
  - Required: int_out=1 for IR2 and the acknowledge gives isr=0x24.
  - A later irr=0x80 is blocked: int_out stays 0.
- Rotation:
  - Stimulus: isr=0x01; non-specific EOI with eoi_rotate=1.
  - Required: isr=0x00 and lowest_reg=0.
  - Then irr=0x81 (imr=0): the IR0/IR7 conflict resolves to IR1-first order, and IR7 is acknowledged before IR0.
- Spurious:
  - Stimulus: int_out=1 for irr=0x10, then irr drops to 0 before the INTA1 falling edge.
  - Required: isr unchanged, clear_irr=0, vector_out={base,3'd7}.
- Auto-EOI:
  - Stimulus: auto_eoi=1, irr=0x02, full INTA sequence.
  - Required: isr=0x02 between pulses; isr=0x00 the cycle after INTA2 rises.
- Reset and conflicts:
  - Stimulus: assert reset during WAIT2.
  - Required: all outputs 0 immediately; no vector_valid after release.
  - Stimulus: a specific EOI of level 3 in the same cycle as INTA1 sets IR3.
  - Required: isr[3]=1.
